cp_rd_dt_conv: RTL and testbench



---
 rtl/cp_rd_pkg.sv | 27 ++
 rtl/cp_rd_word_mux.sv | 12 +
 rtl/cp_rd_dt_conv.sv | 122 ++++++++++++
 tb/tb_cp_rd_dt_conv.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp_rd_pkg.sv
// Shared widths, FSM encoding and lane-select helper for the CpOutBuf read-side converter.
package cp_rd_pkg;

  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 32;
  localparam int LINE_W      = 4 * DATA_W;
  localparam int LINE_ADDR_W = ADDR_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Lane 0 is the least significant word, matching the write-side lane order.
  function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        idx);
    logic [DATA_W-1:0] w;
    case (idx)
      2'd0:    w = line[0*DATA_W +: DATA_W];
      2'd1:    w = line[1*DATA_W +: DATA_W];
      2'd2:    w = line[2*DATA_W +: DATA_W];
      default: w = line[3*DATA_W +: DATA_W];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cp_rd_word_mux.sv
// Combinational 4:1 word select out of a 128-bit line.
module cp_rd_word_mux
  import cp_rd_pkg::*;
(
  input  logic [LINE_W-1:0] iLine,
  input  logic [1:0]        iIdx,
  output logic [DATA_W-1:0] oWord
);

  assign oWord = word_sel(iLine, iIdx);

endmodule

// File: rtl/cp_rd_dt_conv.sv
// Converts 32-bit OutBuf word reads into 128-bit CpOutBuf line reads,
// keeping one fetched line so consecutive same-line reads skip the buffer.
module cp_rd_dt_conv
  import cp_rd_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iRdEn_OutBuf,
  input  logic [ADDR_W-1:0]      iRdAddr_OutBuf,
  output logic                   oRdBusy_OutBuf,
  output logic                   oRdVld_OutBuf,
  output logic [DATA_W-1:0]      oRdDt_OutBuf,
  output logic                   oRdEn_CpOutBuf,
  output logic [LINE_ADDR_W-1:0] oRdAddr_CpOutBuf,
  input  logic [LINE_W-1:0]      iRdDt_CpOutBuf,
  input  logic                   iLineInv
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t                  stateReg, stateNext;
  logic [1:0]              latCntReg;
  logic [LINE_W-1:0]       lineReg;
  logic                    lineVldReg;
  logic [LINE_ADDR_W-1:0]  lineAddrReg;
  logic [LINE_ADDR_W-1:0]  pendAddrReg;
  logic [1:0]              wordIdxReg;
  logic                    invPendReg;
  logic                    rdVldReg;
  logic [DATA_W-1:0]       rdDtReg;

  logic                    accept, hit, miss, capture;
  logic [LINE_ADDR_W-1:0]  reqLine;
  logic [1:0]              reqIdx;
  logic [DATA_W-1:0]       hitWord, capWord;

  assign reqLine = iRdAddr_OutBuf[ADDR_W-1:2];
  assign reqIdx  = iRdAddr_OutBuf[1:0];

  // Same lane select serves the held line (hit) and the returning line (capture).
  cp_rd_word_mux uHitMux (
    .iLine (lineReg),
    .iIdx  (reqIdx),
    .oWord (hitWord)
  );

  cp_rd_word_mux uCapMux (
    .iLine (iRdDt_CpOutBuf),
    .iIdx  (wordIdxReg),
    .oWord (capWord)
  );

  always_ff @(posedge iClk) begin
    if (iRst) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  always_comb begin
    stateNext        = stateReg;
    accept           = iRdEn_OutBuf && (stateReg == IDLE) && !iRst;
    hit              = accept && lineVldReg && (reqLine == lineAddrReg) && !iLineInv;
    miss             = accept && !hit;
    capture          = (stateReg == WAIT) && (latCntReg == LAT_LAST);
    oRdBusy_OutBuf   = (stateReg == WAIT);
    oRdEn_CpOutBuf   = miss;
    oRdAddr_CpOutBuf = miss ? reqLine : '0;
    case (stateReg)
      IDLE:    if (miss)    stateNext = WAIT;
      WAIT:    if (capture) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      latCntReg   <= '0;
      lineReg     <= '0;
      lineVldReg  <= 1'b0;
      lineAddrReg <= '0;
      pendAddrReg <= '0;
      wordIdxReg  <= '0;
      invPendReg  <= 1'b0;
      rdVldReg    <= 1'b0;
      rdDtReg     <= '0;
    end else begin
      rdVldReg <= 1'b0;
      if (hit) begin
        rdVldReg <= 1'b1;
        rdDtReg  <= hitWord;
      end
      // The held line is being replaced, so it stops serving hits right away.
      if (miss) begin
        lineVldReg  <= 1'b0;
        pendAddrReg <= reqLine;
        wordIdxReg  <= reqIdx;
        invPendReg  <= 1'b0;
        latCntReg   <= '0;
      end else if (stateReg == IDLE && iLineInv) begin
        lineVldReg <= 1'b0;
      end
      if (stateReg == WAIT) begin
        latCntReg <= latCntReg + 2'd1;
        if (iLineInv) invPendReg <= 1'b1;
      end
      // A write seen during the fetch makes the captured line stale for later hits.
      if (capture) begin
        lineReg     <= iRdDt_CpOutBuf;
        lineAddrReg <= pendAddrReg;
        lineVldReg  <= !(invPendReg || iLineInv);
        latCntReg   <= '0;
        rdVldReg    <= 1'b1;
        rdDtReg     <= capWord;
      end
    end
  end

  assign oRdVld_OutBuf = rdVldReg;
  assign oRdDt_OutBuf  = rdDtReg;

endmodule

// File: tb/tb_cp_rd_dt_conv.sv
// Bench for cp_rd_dt_conv at RD_LAT 1..3: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level model of the line holder.
module tb_cp_rd_dt_conv;

  logic         clk;
  logic         rst     [3];
  logic         rdEn    [3];
  logic [8:0]   rdAddr  [3];
  logic         lineInv [3];
  logic [127:0] rdDtC   [3];
  logic         busy    [3];
  logic         vld     [3];
  logic [31:0]  dt      [3];
  logic         rdEnC   [3];
  logic [6:0]   rdAddrC [3];

  for (genvar gi = 0; gi < 3; gi++) begin : gDut
    cp_rd_dt_conv #(.RD_LAT(gi + 1)) uDut (
      .iClk             (clk),
      .iRst             (rst[gi]),
      .iRdEn_OutBuf     (rdEn[gi]),
      .iRdAddr_OutBuf   (rdAddr[gi]),
      .oRdBusy_OutBuf   (busy[gi]),
      .oRdVld_OutBuf    (vld[gi]),
      .oRdDt_OutBuf     (dt[gi]),
      .oRdEn_CpOutBuf   (rdEnC[gi]),
      .oRdAddr_CpOutBuf (rdAddrC[gi]),
      .iRdDt_CpOutBuf   (rdDtC[gi]),
      .iLineInv         (lineInv[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       due;
    logic [6:0] addr;
  } fetch_t;

  typedef struct {
    int        due;
    logic [31:0] d;
  } resp_t;

  int           nChk  = 0;
  int           nPass = 0;
  int           cyc   = 0;
  logic [127:0] mem [128];
  fetch_t       fq[$];
  resp_t        rq[$];
  logic         heldVld;
  logic [6:0]   heldAddr;
  int           busyEnd, fillAt;
  logic [1:0]   fillIdx;
  logic         invFetch;
  logic [31:0]  lastDt;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
  endtask

  function automatic logic [31:0] lane(input logic [127:0] l, input logic [1:0] i);
    return 32'((l >> (32 * int'(i))) & 128'hFFFF_FFFF);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic modelReset();
    fq.delete();
    rq.delete();
    heldVld  = 1'b0;
    heldAddr = '0;
    busyEnd  = -1;
    fillAt   = -1;
    fillIdx  = '0;
    invFetch = 1'b0;
    lastDt   = '0;
  endtask

  // One clock of stimulus on instance k, then compare every output with the model.
  task automatic step(input int k, input logic en, input logic [8:0] a,
                      input logic inv, input logic rs);
    logic [127:0] drv;
    logic         busyE, acc, hit, expV;
    int           lat;
    lat = k + 1;
    @(posedge clk);
    #1;
    cyc++;
    rst[k]     = rs;
    rdEn[k]    = en;
    rdAddr[k]  = a;
    lineInv[k] = inv;
    drv = rnd128();
    if (fq.size() > 0 && fq[0].due == cyc) begin
      drv = mem[fq[0].addr];
      void'(fq.pop_front());
    end
    rdDtC[k] = drv;
    @(negedge clk);
    if (rs) begin
      modelReset();
    end else begin
      expV = (rq.size() > 0) && (rq[0].due == cyc);
      chk("vld", 128'(vld[k]), 128'(expV));
      if (expV) begin
        chk("dt", 128'(dt[k]), 128'(rq[0].d));
        $display("rd inst=%0d cyc=%0d dt=%h", k, cyc, dt[k]);
        lastDt = rq[0].d;
        void'(rq.pop_front());
      end else begin
        chk("dtHold", 128'(dt[k]), 128'(lastDt));
      end
      busyE = (cyc <= busyEnd);
      chk("busy", 128'(busy[k]), 128'(busyE));
      acc = en && !busyE;
      hit = acc && heldVld && (heldAddr == a[8:2]) && !inv;
      chk("rdEnC", 128'(rdEnC[k]), 128'(acc && !hit));
      if (busyE && inv) invFetch = 1'b1;
      if (hit) rq.push_back('{due: cyc + 1, d: lane(mem[a[8:2]], a[1:0])});
      if (acc && !hit) begin
        chk("rdAddrC", 128'(rdAddrC[k]), 128'(a[8:2]));
        fq.push_back('{due: cyc + lat, addr: a[8:2]});
        busyEnd  = cyc + lat;
        fillAt   = cyc + lat;
        heldVld  = 1'b0;
        heldAddr = a[8:2];
        fillIdx  = a[1:0];
        invFetch = 1'b0;
      end else if (!busyE && inv) begin
        heldVld = 1'b0;
      end
      if (cyc == fillAt) begin
        heldVld = !invFetch;
        rq.push_back('{due: cyc + 1, d: lane(drv, fillIdx)});
      end
      // An invalidate stands for a core write: change the held line's contents.
      if (inv) mem[heldAddr] = rnd128();
    end
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 9'h000, 1'b0, 1'b0);
  endtask

  task automatic resetInst(input int k);
    modelReset();
    step(k, 1'b0, 9'h000, 1'b0, 1'b1);
    step(k, 1'b0, 9'h000, 1'b0, 1'b0);
    chk("rstRdAddr", 128'(rdAddrC[k]), 128'(0));
  endtask

  task automatic randomRun(input int k, input int n);
    logic       rs, en, inv;
    logic [6:0] ln;
    for (int i = 0; i < n; i++) begin
      rs  = ($urandom_range(0, 99) < 2);
      en  = !rs && ($urandom_range(0, 99) < 70);
      inv = !rs && ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       ln = 7'h00;
        1:       ln = 7'h01;
        2:       ln = 7'h7F;
        default: ln = 7'($urandom());
      endcase
      step(k, en, {ln, 2'($urandom())}, inv, rs);
    end
    idle(k, 5);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; rdEn[i] = 1'b0; rdAddr[i] = '0; lineInv[i] = 1'b0; rdDtC[i] = '0;
    end
    for (int i = 0; i < 128; i++) mem[i] = rnd128();
    mem[1] = 128'h44444444_33333333_22222222_11111111;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // RD_LAT=1: first miss, same-line hits, invalidate with request, invalidate on capture
    resetInst(0);
    step(0, 1'b1, 9'h005, 1'b0, 1'b0);
    idle(0, 2);
    step(0, 1'b1, 9'h004, 1'b0, 1'b0);
    step(0, 1'b1, 9'h006, 1'b0, 1'b0);
    step(0, 1'b1, 9'h007, 1'b0, 1'b0);
    idle(0, 2);
    step(0, 1'b1, 9'h005, 1'b1, 1'b0);
    idle(0, 2);
    step(0, 1'b1, 9'h006, 1'b0, 1'b0);
    idle(0, 2);
    step(0, 1'b1, 9'h010, 1'b0, 1'b0);
    step(0, 1'b0, 9'h000, 1'b1, 1'b0);
    idle(0, 1);
    step(0, 1'b1, 9'h011, 1'b0, 1'b0);
    idle(0, 3);
    randomRun(0, 400);

    // RD_LAT=2: reset in the middle of a miss
    resetInst(1);
    step(1, 1'b1, 9'h008, 1'b0, 1'b0);
    step(1, 1'b0, 9'h000, 1'b0, 1'b1);
    idle(1, 4);
    step(1, 1'b1, 9'h008, 1'b0, 1'b0);
    idle(1, 4);
    randomRun(1, 400);

    // RD_LAT=3: top line address, request held and changed while busy
    resetInst(2);
    step(2, 1'b1, 9'h1FC, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(2, 1'b1, 9'h000, 1'b0, 1'b0);
    idle(2, 5);
    randomRun(2, 400);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
